// File: rtl/unary_to_bcd_collector.sv
// unary_to_bcd_collector
//
// Downstream stage of the unary mod-10 digit adder. Every write phase of the
// adder emits a burst of unary pulses on its dout. This block counts each burst,
// converts the count into one BCD digit, and latches the adder carry that was
// present when the write phase began. It collects DIGITS digits, least
// significant first, into a packed BCD word. The word is offered on a
// valid/ready output together with the carry of the most-significant digit.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   en             stage enable, shared with the adder; 0 freezes collection
//   read_or_write  adder phase: 0 = read (summing), 1 = write (emitting pulses)
//   din            adder dout, one pulse per unit of digit value
//   cin            adder carry out of the current digit
//   out_ready      consumer accepts the result
//   out_valid      bcd_out / carry_out hold a complete result
//   bcd_out        packed BCD result, digit 0 in bits [3:0]
//   carry_out      carry latched with the most-significant digit
//   digit_err      sticky: some burst was longer than 9 pulses
//   overrun        sticky: a write phase began while a result was unaccepted
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE    | waiting for a write phase to start; pulse counter held at 0
// COLLECT | write phase active, counting din pulses
// DRAIN   | one extra enabled cycle after the phase ends, to catch the
//         | adder's lagging registered pulse
// COMMIT  | saturate the count to a digit and store it (one clk cycle)
// OUT     | full result presented; wait for the consumer handshake

module unary_to_bcd_collector #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  read_or_write,
    input  logic                  din,
    input  logic                  cin,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  carry_out,
    output logic                  digit_err,
    output logic                  overrun
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_DRAIN   = 3'd2,
        S_COMMIT  = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [3:0]            pulse_cnt_q, pulse_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic                  rw_d_q,      rw_d_d;
    logic                  carry_lat_q, carry_lat_d;
    logic [4*DIGITS-1:0]   shreg_q,     shreg_d;
    logic                  out_valid_q, out_valid_d;
    logic [4*DIGITS-1:0]   bcd_out_q,   bcd_out_d;
    logic                  carry_out_q, carry_out_d;
    logic                  digit_err_q, digit_err_d;
    logic                  overrun_q,   overrun_d;

    logic                  rise;
    logic                  fall;
    logic                  handshake;
    logic [3:0]            cnt_inc;
    logic [3:0]            digit_sat;

    // Phase edges are only seen on enabled cycles, so a phase change while
    // en=0 is picked up on the next enabled cycle.
    assign rise      = en & ~rw_d_q &  read_or_write;
    assign fall      = en &  rw_d_q & ~read_or_write;
    assign handshake = out_valid_q & out_ready;

    // Counter saturates at 15 so a very long burst can never wrap back
    // into the legal 0..9 range.
    assign cnt_inc   = (pulse_cnt_q == 4'hF) ? pulse_cnt_q : (pulse_cnt_q + 4'd1);
    assign digit_sat = (pulse_cnt_q > 4'd9) ? 4'd9 : pulse_cnt_q;

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        digit_idx_d = digit_idx_q;
        rw_d_d      = rw_d_q;
        carry_lat_d = carry_lat_q;
        shreg_d     = shreg_q;
        out_valid_d = out_valid_q;
        bcd_out_d   = bcd_out_q;
        carry_out_d = carry_out_q;
        digit_err_d = digit_err_q;
        overrun_d   = overrun_q;

        if (en) begin
            rw_d_d = read_or_write;
        end

        case (state_q)
            S_IDLE: begin
                pulse_cnt_d = 4'd0;
                if (rise) begin
                    carry_lat_d = cin;
                    state_d     = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (en && din) begin
                    pulse_cnt_d = cnt_inc;
                end
                if (fall) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (en) begin
                    if (din) begin
                        pulse_cnt_d = cnt_inc;
                    end
                    state_d = S_COMMIT;
                end
            end

            S_COMMIT: begin
                if (pulse_cnt_q > 4'd9) begin
                    digit_err_d = 1'b1;
                end
                // Each digit is written straight into its final nibble. This
                // gives the same result as shifting digits in at the top:
                // digit 0 ends up in [3:0] after DIGITS commits.
                for (int i = 0; i < DIGITS; i++) begin
                    if (digit_idx_q == IDX_W'(i)) begin
                        shreg_d[4*i +: 4] = digit_sat;
                    end
                end
                pulse_cnt_d = 4'd0;
                if (digit_idx_q == LAST_IDX) begin
                    bcd_out_d   = shreg_d;
                    carry_out_d = carry_lat_q;
                    out_valid_d = 1'b1;
                    digit_idx_d = '0;
                    state_d     = S_OUT;
                end else begin
                    digit_idx_d = digit_idx_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end

            S_OUT: begin
                pulse_cnt_d = 4'd0;
                // A write phase that starts here is dropped. rw_d still
                // follows the phase, so its later fall in IDLE does nothing.
                if (rise && !handshake) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pulse_cnt_q <= 4'd0;
            digit_idx_q <= '0;
            rw_d_q      <= 1'b0;
            carry_lat_q <= 1'b0;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            carry_out_q <= 1'b0;
            digit_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            digit_idx_q <= digit_idx_d;
            rw_d_q      <= rw_d_d;
            carry_lat_q <= carry_lat_d;
            shreg_q     <= shreg_d;
            out_valid_q <= out_valid_d;
            bcd_out_q   <= bcd_out_d;
            carry_out_q <= carry_out_d;
            digit_err_q <= digit_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;
    assign carry_out = carry_out_q;
    assign digit_err = digit_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_unary_to_bcd_collector.sv
// Testbench for unary_to_bcd_collector: a DIGITS=1 instance and a DIGITS=4
// instance share one stimulus bus. Each scenario is a task with its own
// inline comparisons.

module tb_unary_to_bcd_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rw;
    logic        din;
    logic        cin;
    logic        out_ready;

    logic        ov1;
    logic [3:0]  bcd1;
    logic        co1;
    logic        de1;
    logic        or1;

    logic        ov4;
    logic [15:0] bcd4;
    logic        co4;
    logic        de4;
    logic        or4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unary_to_bcd_collector #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din),
        .cin(cin), .out_ready(out_ready), .out_valid(ov1), .bcd_out(bcd1),
        .carry_out(co1), .digit_err(de1), .overrun(or1)
    );

    unary_to_bcd_collector #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din),
        .cin(cin), .out_ready(out_ready), .out_valid(ov4), .bcd_out(bcd4),
        .carry_out(co4), .digit_err(de4), .overrun(or4)
    );

    // Inputs change 1 ns after a rising edge, and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rw = 1'b0; din = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One write phase carrying n pulses, ending after the DRAIN cycle.
    // mode 0: all pulses while read_or_write=1
    // mode 1: last pulse in the fall cycle (first read cycle)
    // mode 2: last pulse one cycle after the fall cycle (the DRAIN cycle)
    task automatic burst(input int n, input int mode, input logic c);
        cin = c;
        rw  = 1'b1; din = 1'b0;
        tick();
        if (mode == 0) begin
            for (int i = 0; i < n; i++) begin
                din = 1'b1; tick();
            end
            rw = 1'b0; din = 1'b0; tick();
            din = 1'b0; tick();
        end else if (mode == 1) begin
            for (int i = 0; i < n - 1; i++) begin
                din = 1'b1; tick();
            end
            rw = 1'b0; din = 1'b1; tick();
            din = 1'b0; tick();
        end else begin
            for (int i = 0; i < n - 1; i++) begin
                din = 1'b1; tick();
            end
            rw = 1'b0; din = 1'b0; tick();
            din = 1'b1; tick();
        end
        din = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; rw = 1'b1; din = 1'b1; cin = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", ov4); end
        checks++; if (bcd4 !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %04h exp 0000", bcd4); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL reset_carry: got %0b exp 0", co4); end
        checks++; if (de4 !== 1'b0) begin errors++; $display("FAIL reset_digit_err: got %0b exp 0", de4); end
        checks++; if (or4 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b exp 0", or4); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %0b exp 0", ov1); end
        rst_n = 1'b1; rw = 1'b0; din = 1'b0; cin = 1'b0;
        tick();
    endtask

    task automatic test_single_digit();
        out_ready = 1'b0;
        cin = 1'b1; rw = 1'b0;
        tick();
        tick();
        burst(7, 0, 1'b1);
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL single_latency: got %0b exp 0", ov1); end
        tick();
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b exp 1", ov1); end
        checks++; if (bcd1 !== 4'h7) begin errors++; $display("FAIL single_bcd: got %0h exp 7", bcd1); end
        checks++; if (co1 !== 1'b1) begin errors++; $display("FAIL single_carry: got %0b exp 1", co1); end
        out_ready = 1'b1;
        tick();
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL single_handshake: got %0b exp 0", ov1); end
        out_ready = 1'b0;
    endtask

    task automatic test_four_digits();
        do_reset();
        burst(3, 0, 1'b1); tick();
        burst(0, 0, 1'b1); tick();
        burst(9, 0, 1'b1); tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL multi_early_valid: got %0b exp 0", ov4); end
        burst(5, 0, 1'b0);
        tick();
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL multi_valid: got %0b exp 1", ov4); end
        checks++; if (bcd4 !== 16'h5903) begin errors++; $display("FAIL multi_bcd: got %04h exp 5903", bcd4); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL multi_carry: got %0b exp 0", co4); end
        checks++; if (de4 !== 1'b0) begin errors++; $display("FAIL multi_digit_err: got %0b exp 0", de4); end
        out_ready = 1'b1;
        tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL multi_handshake: got %0b exp 0", ov4); end
        out_ready = 1'b0;
    endtask

    task automatic test_lagged_pulse();
        burst(4, 2, 1'b0); tick();
        burst(2, 1, 1'b0); tick();
        burst(0, 0, 1'b0); tick();
        burst(1, 0, 1'b1); tick();
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL lag_valid: got %0b exp 1", ov4); end
        checks++; if (bcd4 !== 16'h1024) begin errors++; $display("FAIL lag_bcd: got %04h exp 1024", bcd4); end
        checks++; if (co4 !== 1'b1) begin errors++; $display("FAIL lag_carry: got %0b exp 1", co4); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_enable_gap();
        cin = 1'b1;
        rw = 1'b1; din = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; tick();
        end
        // Frozen: pulses and a phase change while en=0 must both be ignored.
        en = 1'b0; rw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; tick();
        end
        en = 1'b1; rw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; tick();
        end
        rw = 1'b0; din = 1'b0; tick();
        tick();
        tick();
        burst(8, 0, 1'b1); tick();
        burst(0, 0, 1'b1); tick();
        burst(2, 0, 1'b0); tick();
        checks++; if (bcd4 !== 16'h2086) begin errors++; $display("FAIL engap_bcd: got %04h exp 2086", bcd4); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL engap_carry: got %0b exp 0", co4); end
        checks++; if (de4 !== 1'b0) begin errors++; $display("FAIL engap_digit_err: got %0b exp 0", de4); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow_backpressure();
        burst(12, 0, 1'b1); tick();
        checks++; if (de4 !== 1'b1) begin errors++; $display("FAIL ovf_digit_err: got %0b exp 1", de4); end
        burst(1, 0, 1'b1); tick();
        burst(1, 0, 1'b1); tick();
        burst(1, 0, 1'b1); tick();
        checks++; if (bcd4 !== 16'h1119) begin errors++; $display("FAIL ovf_bcd: got %04h exp 1119", bcd4); end
        checks++; if (or4 !== 1'b0) begin errors++; $display("FAIL ovf_no_overrun: got %0b exp 0", or4); end
        burst(5, 0, 1'b0); tick();
        checks++; if (or4 !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %0b exp 1", or4); end
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %0b exp 1", ov4); end
        checks++; if (bcd4 !== 16'h1119) begin errors++; $display("FAIL bp_bcd_held: got %04h exp 1119", bcd4); end
        checks++; if (co4 !== 1'b1) begin errors++; $display("FAIL bp_carry_held: got %0b exp 1", co4); end
        out_ready = 1'b1;
        tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b exp 0", ov4); end
        out_ready = 1'b0;
        // The dropped burst must not have consumed a digit slot.
        burst(1, 0, 1'b0); tick();
        burst(2, 0, 1'b0); tick();
        burst(3, 0, 1'b0); tick();
        burst(4, 0, 1'b0); tick();
        checks++; if (bcd4 !== 16'h4321) begin errors++; $display("FAIL drop_bcd: got %04h exp 4321", bcd4); end
        checks++; if (de4 !== 1'b1) begin errors++; $display("FAIL sticky_digit_err: got %0b exp 1", de4); end
        // A write phase starting in the handshake cycle is dropped as well.
        out_ready = 1'b1;
        burst(5, 0, 1'b0); tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL hs_rise_valid: got %0b exp 0", ov4); end
        burst(5, 0, 1'b0); tick();
        burst(6, 0, 1'b0); tick();
        burst(7, 0, 1'b0); tick();
        burst(8, 0, 1'b0); tick();
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL hs_rise_result_valid: got %0b exp 1", ov4); end
        checks++; if (bcd4 !== 16'h8765) begin errors++; $display("FAIL hs_rise_bcd: got %04h exp 8765", bcd4); end
        tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL hs_rise_release: got %0b exp 0", ov4); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_collect();
        burst(1, 0, 1'b0); tick();
        burst(2, 0, 1'b0); tick();
        cin = 1'b1; rw = 1'b1; din = 1'b0;
        tick();
        din = 1'b1; tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b exp 0", ov4); end
        checks++; if (bcd4 !== 16'h0000) begin errors++; $display("FAIL mid_rst_bcd: got %04h exp 0000", bcd4); end
        checks++; if (de4 !== 1'b0) begin errors++; $display("FAIL mid_rst_digit_err: got %0b exp 0", de4); end
        checks++; if (or4 !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun: got %0b exp 0", or4); end
        rst_n = 1'b1; rw = 1'b0; din = 1'b0;
        tick();
        burst(3, 0, 1'b0); tick();
        burst(4, 0, 1'b0); tick();
        burst(5, 0, 1'b0); tick();
        burst(6, 0, 1'b1); tick();
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL fresh_valid: got %0b exp 1", ov4); end
        checks++; if (bcd4 !== 16'h6543) begin errors++; $display("FAIL fresh_bcd: got %04h exp 6543", bcd4); end
        checks++; if (co4 !== 1'b1) begin errors++; $display("FAIL fresh_carry: got %0b exp 1", co4); end
        checks++; if (de4 !== 1'b0) begin errors++; $display("FAIL fresh_digit_err: got %0b exp 0", de4); end
        checks++; if (or4 !== 1'b0) begin errors++; $display("FAIL fresh_overrun: got %0b exp 0", or4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; rw = 1'b0; din = 1'b0; cin = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_digit();
        test_four_digits();
        test_lagged_pulse();
        test_enable_gap();
        test_overflow_backpressure();
        test_reset_mid_collect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
